// File: rtl/mul_sequencer_if.sv
// Handshake and shared-ALU bundle between the
// pipeline control and the MUL sequencer.
interface mul_sequencer_if #(
  parameter int N = 64
);
  logic         start;
  logic [N-1:0] multiplicand;
  logic [N-1:0] multiplier;
  logic [N-1:0] aluResult;
  logic         busy;
  logic         done;
  logic [N-1:0] product;
  logic         aluOwn;
  logic         AluSrc;
  logic [3:0]   AluControl;
  logic [N-1:0] aluA;
  logic [N-1:0] aluB;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    output aluResult,
    input  busy,
    input  done,
    input  product,
    input  aluOwn,
    input  AluSrc,
    input  AluControl,
    input  aluA,
    input  aluB
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    input  aluResult,
    output busy,
    output done,
    output product,
    output aluOwn,
    output AluSrc,
    output AluControl,
    output aluA,
    output aluB
  );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-and-add MUL controller that borrows the
// execute-stage ALU for one ADD per multiplier bit.
module mul_sequencer #(
  parameter int N = 64
) (
  input  logic          clk,
  input  logic          reset,
  mul_sequencer_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [N-1:0]   acc;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [N-1:0]   product_q;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   mplier_sh;
  logic           last;

  assign mplier_sh = mplier >> 1;
  // Stop early once no set bits remain
  assign last = (mplier_sh == '0) ||
                (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= bus.multiplicand;
            mplier <= bus.multiplier;
            acc    <= '0;
            cnt    <= '0;
            if (bus.multiplier == '0)
              product_q <= '0;
          end
        end
        RUN: begin
          acc    <= bus.aluResult;
          mcand  <= mcand << 1;
          mplier <= mplier_sh;
          cnt    <= cnt + CW'(1);
          if (last)
            product_q <= bus.aluResult;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nx       = state;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.aluOwn     = 1'b0;
    bus.AluSrc     = 1'b0;
    bus.AluControl = 4'b0000;
    bus.aluA       = '0;
    bus.aluB       = '0;
    unique case (state)
      IDLE: begin
        if (bus.start)
          state_nx = (bus.multiplier == '0) ?
                     DONE : RUN;
      end
      RUN: begin
        bus.busy       = 1'b1;
        bus.aluOwn     = 1'b1;
        bus.AluControl = 4'b0010;
        bus.aluA       = acc;
        bus.aluB       = mplier[0] ? mcand : '0;
        if (last)
          state_nx = DONE;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.product = product_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer with a
// behavioural adder standing in for the ALU.
module tb_mul_sequencer;
  logic clk = 1'b0;
  logic reset;

  mul_sequencer_if #(.N(64)) bus ();

  mul_sequencer #(.N(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.aluResult = bus.aluA + bus.aluB;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] p;
    int          m;
  } vec_t;

  vec_t        vecs [7];
  logic [63:0] sb [$];
  logic [63:0] last_p;
  int          checks;
  int          errors;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic run_op(input logic [63:0] a,
                        input logic [63:0] b,
                        input logic [63:0] p,
                        input int m,
                        input bit ign);
    logic [63:0] acc_m;
    logic [63:0] mc_m;
    logic [63:0] mp_m;
    int done_at;
    int owns;
    int busys;
    int dones;
    bit alu_ok;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    sb.push_back(p);
    @(posedge clk);
    #1 bus.start = 1'b0;
    acc_m   = '0;
    mc_m    = a;
    mp_m    = b;
    done_at = 0;
    owns    = 0;
    busys   = 0;
    dones   = 0;
    alu_ok  = 1'b1;
    for (int k = 1; k <= m + 4; k++) begin
      @(negedge clk);
      if (k == 1 && m > 0)
        chk("prod_hold", bus.product, last_p);
      if (bus.AluSrc !== 1'b0)
        alu_ok = 1'b0;
      if (bus.aluOwn === 1'b1) begin
        owns++;
        if (bus.aluA !== acc_m ||
            bus.aluB !== (mp_m[0] ? mc_m : 64'd0) ||
            bus.AluControl !== 4'b0010)
          alu_ok = 1'b0;
        acc_m = acc_m + (mp_m[0] ? mc_m : 64'd0);
        mc_m  = mc_m << 1;
        mp_m  = mp_m >> 1;
      end else if (bus.aluA !== 64'd0 ||
                   bus.aluB !== 64'd0 ||
                   bus.AluControl !== 4'b0000) begin
        alu_ok = 1'b0;
      end
      if (bus.busy === 1'b1)
        busys++;
      if (bus.done === 1'b1) begin
        dones++;
        if (done_at == 0) begin
          done_at = k;
          if (sb.size() > 0)
            chk("product", bus.product,
                sb.pop_front());
          else
            chk("sb_empty", 64'd1, 64'd0);
        end
      end
      if (ign && (k == 2 || k == m + 1)) begin
        bus.start        = 1'b1;
        bus.multiplicand = ~a;
        bus.multiplier   = 64'h3;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("done_cycle", 64'(done_at), 64'(m + 1));
    chk("run_cycles", 64'(owns), 64'(m));
    chk("busy_cycles", 64'(busys), 64'(m + 1));
    chk("done_pulses", 64'(dones), 64'd1);
    chk("alu_drive", 64'(alu_ok), 64'd1);
    last_p = p;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    last_p = '0;
    vecs[0] = '{64'd3, 64'd5, 64'd15, 3};
    vecs[1] = '{64'd9, 64'd0, 64'd0, 0};
    vecs[2] = '{64'd1, 64'h8000_0000_0000_0000,
                64'h8000_0000_0000_0000, 64};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'd3,
                64'h8000_0000_0000_0000, 2};
    vecs[4] = '{'1, '1, 64'd1, 64};
    vecs[5] = '{64'h1234_5678_9abc_def0, 64'hff,
                64'h2222_2222_2222_1110, 8};
    vecs[6] = '{64'd6, 64'd7, 64'd42, 3};

    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_own", 64'(bus.aluOwn), 64'd0);
    chk("rst_src", 64'(bus.AluSrc), 64'd0);
    chk("rst_ctl", 64'(bus.AluControl), 64'd0);
    chk("rst_a", bus.aluA, 64'd0);
    chk("rst_b", bus.aluB, 64'd0);
    chk("rst_prod", bus.product, 64'd0);
    reset = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0)
        n++;
    end
    chk("idle_quiet", 64'(n), 64'd0);

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].p,
             vecs[i].m, 1'b0);

    run_op(64'd3, 64'd5, 64'd15, 3, 1'b1);

    // Abort 7x255 partway through its RUN phase
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 64'd7;
    bus.multiplier   = 64'd255;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_own", 64'(bus.aluOwn), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_prod", bus.product, 64'd0);
    reset = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0)
        n++;
    end
    chk("mid_rst_quiet", 64'(n), 64'd0);
    last_p = '0;
    run_op(64'd6, 64'd7, 64'd42, 3, 1'b0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
